// File: rtl/seq_control_fsm_pkg.sv
// seq_ctrl_pkg: opcodes, execute lengths and state-code layout for seq_control_fsm.
package seq_ctrl_pkg;
    localparam int OP_END  = 0;
    localparam int OP_LDR1 = 1;
    localparam int OP_LDR2 = 2;
    localparam int OP_STAC = 3;
    localparam int OP_ADD  = 4;
    localparam int OP_MUL  = 5;
    localparam int OP_JMP  = 6;
    localparam int OP_JMPZ = 7;
    localparam int OP_NOP  = 8;
    localparam int OP_HLT  = 9;
    localparam int OP_LEGAL_MAX = OP_HLT;

    localparam int LEN_LDR1  = 4;
    localparam int LEN_LDR2  = 4;
    localparam int LEN_STAC  = 4;
    localparam int LEN_ADD   = 2;
    localparam int LEN_MUL   = 1;
    localparam int LEN_JMP   = 3;
    localparam int LEN_JSKIP = 1;
    localparam int LEN_NOP   = 1;

    typedef enum logic [2:0] {PH_IDLE, PH_FETCH, PH_DEC, PH_EXEC, PH_HALT, PH_BAD} phase_t;

    // Execute blocks are packed back to back after the last fetch state.
    function automatic int f_base(int fl);
        return 1 + 0 * fl;
    endfunction
    function automatic int ldr1_base(int fl);
        return fl + 1;
    endfunction
    function automatic int ldr2_base(int fl);
        return ldr1_base(fl) + LEN_LDR1;
    endfunction
    function automatic int stac_base(int fl);
        return ldr2_base(fl) + LEN_LDR2;
    endfunction
    function automatic int add_base(int fl);
        return stac_base(fl) + LEN_STAC;
    endfunction
    function automatic int mul_base(int fl);
        return add_base(fl) + LEN_ADD;
    endfunction
    function automatic int jmp_base(int fl);
        return mul_base(fl) + LEN_MUL;
    endfunction
    function automatic int jskip_base(int fl);
        return jmp_base(fl) + LEN_JMP;
    endfunction
    function automatic int nop_base(int fl);
        return jskip_base(fl) + LEN_JSKIP;
    endfunction
    function automatic int s_halt(int fl);
        return nop_base(fl) + LEN_NOP;
    endfunction
endpackage

// File: rtl/seq_control_fsm_if.sv
// seq_control_fsm_if: run controls, IR and status outputs of the instruction sequencer.
interface seq_control_fsm_if #(
    parameter int IR_W    = 16,
    parameter int STATE_W = 6
);
    logic               start;
    logic               stall;
    logic               z_flag;
    logic [IR_W-1:0]    IR;
    logic [STATE_W-1:0] state;
    logic               instr_done;
    logic               halted;
    logic               illegal_op;
    modport master (output start, stall, z_flag, IR, input state, instr_done, halted, illegal_op);
    modport slave  (input start, stall, z_flag, IR, output state, instr_done, halted, illegal_op);
endinterface

// File: rtl/seq_control_fsm.sv
// seq_control_fsm: fetch/decode/execute state sequencer with stall, halt and illegal-opcode detection.
module seq_control_fsm
    import seq_ctrl_pkg::*;
#(
    parameter int IR_W      = 16,
    parameter int OPC_W     = 6,
    parameter int STATE_W   = 6,
    parameter int FETCH_LEN = 6
) (
    input  logic              clock,
    input  logic              reset_n,
    seq_control_fsm_if.slave  bus
);
    localparam int C_F1    = f_base(FETCH_LEN);
    localparam int C_LDR1  = ldr1_base(FETCH_LEN);
    localparam int C_LDR2  = ldr2_base(FETCH_LEN);
    localparam int C_STAC  = stac_base(FETCH_LEN);
    localparam int C_ADD   = add_base(FETCH_LEN);
    localparam int C_MUL   = mul_base(FETCH_LEN);
    localparam int C_JMP   = jmp_base(FETCH_LEN);
    localparam int C_JSKIP = jskip_base(FETCH_LEN);
    localparam int C_NOP   = nop_base(FETCH_LEN);
    localparam int C_HALT  = s_halt(FETCH_LEN);

    if (C_HALT >= (1 << STATE_W)) begin : g_bad_state_w
        $error("STATE_W too narrow for highest state code");
    end
    if (OPC_W > IR_W) begin : g_bad_opc_w
        $error("OPC_W exceeds IR_W");
    end
    if (FETCH_LEN < 1 || FETCH_LEN > 8) begin : g_bad_fetch_len
        $error("FETCH_LEN outside 1..8");
    end

    logic [STATE_W-1:0] r_state;
    logic               r_instr_done;
    logic               r_halted;
    logic               r_illegal;
    int                 w_cur;
    int                 w_opc;
    int                 w_next;
    phase_t             w_phase;
    logic               w_last;
    logic               w_done;
    logic               w_illegal;
    logic               w_unused;

    assign w_unused = ^bus.IR;

    always_comb begin
        w_cur   = int'(r_state);
        w_opc   = int'(bus.IR[IR_W-1 -: OPC_W]);
        w_phase = w_cur == 0         ? PH_IDLE  :
                  w_cur < FETCH_LEN  ? PH_FETCH :
                  w_cur == FETCH_LEN ? PH_DEC   :
                  w_cur < C_HALT     ? PH_EXEC  :
                  w_cur == C_HALT    ? PH_HALT  : PH_BAD;
        // JMPZ taken shares the JMP block, so its last state is the JMP last state.
        w_last  = w_cur == C_LDR1 + LEN_LDR1 - 1 || w_cur == C_LDR2 + LEN_LDR2 - 1 ||
                  w_cur == C_STAC + LEN_STAC - 1 || w_cur == C_ADD + LEN_ADD - 1 ||
                  w_cur == C_MUL + LEN_MUL - 1   || w_cur == C_JMP + LEN_JMP - 1 ||
                  w_cur == C_JSKIP + LEN_JSKIP - 1 || w_cur == C_NOP + LEN_NOP - 1;
        w_next    = 0;
        w_done    = 1'b0;
        w_illegal = 1'b0;
        case (w_phase)
            PH_IDLE, PH_FETCH: w_next = w_cur + 1;
            PH_DEC: begin
                w_illegal = w_opc > OP_LEGAL_MAX;
                case (w_opc)
                    OP_END:  w_next = 0;
                    OP_LDR1: w_next = C_LDR1;
                    OP_LDR2: w_next = C_LDR2;
                    OP_STAC: w_next = C_STAC;
                    OP_ADD:  w_next = C_ADD;
                    OP_MUL:  w_next = C_MUL;
                    OP_JMP:  w_next = C_JMP;
                    OP_JMPZ: w_next = bus.z_flag ? C_JMP : C_JSKIP;
                    OP_NOP:  w_next = C_NOP;
                    default: w_next = C_HALT;
                endcase
            end
            PH_EXEC: begin
                w_next = w_last ? C_F1 : w_cur + 1;
                w_done = w_last;
            end
            PH_HALT: w_next = C_HALT;
            default: w_next = 0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n || !bus.start) begin
            r_state      <= '0;
            r_instr_done <= 1'b0;
            r_halted     <= 1'b0;
            r_illegal    <= 1'b0;
        end else if (bus.stall) begin
            r_instr_done <= 1'b0;
        end else begin
            r_state      <= STATE_W'(w_next);
            r_instr_done <= w_done;
            r_halted     <= w_next == C_HALT;
            r_illegal    <= r_illegal | w_illegal;
        end
    end

    assign bus.state      = r_state;
    assign bus.instr_done = r_instr_done;
    assign bus.halted     = r_halted;
    assign bus.illegal_op = r_illegal;
endmodule
